lc3_regfile: RTL

- LC-3 general-purpose register file, R0..R7, directly downstream of the 3-to-8 destination-register decoder; consumes its one-hot DR select.
- Two combinational read ports (SR1/SR2) feed the ALU and address adders.
- Holds the NZP condition-code register.
- Provides a handshaked debug dump engine that streams R0..R7 out for trace/monitor logic.

---
 rtl/lc3_pkg.sv | 29 ++
 rtl/lc3_regfile_if.sv | 29 ++
 rtl/lc3_cc_gen.sv | 19 +
 rtl/lc3_regfile.sv | 118 +++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 widths, condition-code encodings, dump states and select helpers
package lc3_pkg;

    localparam int LC3_WIDTH = 16;
    localparam int LC3_NREGS = 8;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    typedef enum logic {
        DUMP_IDLE,
        DUMP_SEND
    } dump_state_e;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] onehot8_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lc3_regfile_if.sv
// rtl/lc3_regfile_if.sv - register dump stream: request, valid/ready beats, done pulse
interface lc3_regfile_if #(
    parameter int WIDTH = 16
);
    logic             dump_req;
    logic             dump_valid;
    logic             dump_ready;
    logic [2:0]       dump_idx;
    logic [WIDTH-1:0] dump_data;
    logic             dump_done;

    modport master (
        input  dump_req,
        input  dump_ready,
        output dump_valid,
        output dump_idx,
        output dump_data,
        output dump_done
    );

    modport slave (
        output dump_req,
        output dump_ready,
        input  dump_valid,
        input  dump_idx,
        input  dump_data,
        input  dump_done
    );
endinterface

// File: rtl/lc3_cc_gen.sv
// rtl/lc3_cc_gen.sv - NZP classification of a data word
module lc3_cc_gen
    import lc3_pkg::*;
#(
    parameter int WIDTH = LC3_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output logic [2:0]       nzp
);

    always_comb begin
        nzp = CC_P;
        if (data[WIDTH-1])
            nzp = CC_N;
        else if (data == '0)
            nzp = CC_Z;
    end

endmodule

// File: rtl/lc3_regfile.sv
// rtl/lc3_regfile.sv - LC-3 R0..R7 with one-hot write select, NZP register and dump engine
module lc3_regfile
    import lc3_pkg::*;
#(
    parameter int WIDTH  = LC3_WIDTH,
    parameter int NREGS  = LC3_NREGS,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_reg,
    input  logic [7:0]       dr_onehot,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ld_cc,
    input  logic [2:0]       sr1,
    input  logic [2:0]       sr2,
    output logic [WIDTH-1:0] sr1_data,
    output logic [WIDTH-1:0] sr2_data,
    output logic [2:0]       cc_nzp,
    output logic             sel_err,
    lc3_regfile_if.master    dump
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [2:0]       cc_q, cc_d, cc_new;
    logic             sel_err_q, sel_err_d;
    dump_state_e      state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             done_q, done_d;

    logic       wr_ok;
    logic [2:0] wr_idx;

    assign wr_ok  = ld_reg && is_onehot8(dr_onehot);
    assign wr_idx = onehot8_idx(dr_onehot);

    lc3_cc_gen #(.WIDTH(WIDTH)) u_cc_gen (
        .data (wr_data),
        .nzp  (cc_new)
    );

    always_comb begin
        regs_d = regs_q;
        if (wr_ok)
            regs_d[wr_idx] = wr_data;
        cc_d      = ld_cc ? cc_new : cc_q;
        sel_err_d = sel_err_q | (ld_reg & ~wr_ok);
    end

    // Bypass only forwards well-formed writes, so reads never see a dropped write.
    always_comb begin
        sr1_data = regs_q[sr1];
        sr2_data = regs_q[sr2];
        if (BYPASS != 0 && wr_ok && wr_idx == sr1)
            sr1_data = wr_data;
        if (BYPASS != 0 && wr_ok && wr_idx == sr2)
            sr2_data = wr_data;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            DUMP_IDLE: begin
                if (dump.dump_req) begin
                    state_d = DUMP_SEND;
                    idx_d   = 3'd0;
                end
            end
            DUMP_SEND: begin
                if (dump.dump_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d = DUMP_IDLE;
                        idx_d   = 3'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = DUMP_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
            cc_q      <= CC_Z;
            sel_err_q <= 1'b0;
            state_q   <= DUMP_IDLE;
            idx_q     <= 3'd0;
            done_q    <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            cc_q      <= cc_d;
            sel_err_q <= sel_err_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
        end
    end

    assign cc_nzp  = cc_q;
    assign sel_err = sel_err_q;

    // Dump beats carry the stored value, never the bypassed write.
    assign dump.dump_valid = (state_q == DUMP_SEND);
    assign dump.dump_idx   = idx_q;
    assign dump.dump_data  = regs_q[idx_q];
    assign dump.dump_done  = done_q;

endmodule
